// File: rtl/i2c_shim_filt.sv
// Multi-bus I2C pin shim: open-drain outbound drive, synchronised/glitch-filtered
// inbound pins, and per-bus START/STOP, busy and SCL-stuck-low status.
module i2c_shim_filt #(
  parameter int NUM_BUS      = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int STUCK_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_BUS-1:0] i_scl_o,
  input  logic [NUM_BUS-1:0] i_scl_t,
  output logic [NUM_BUS-1:0] i_scl_i,
  input  logic [NUM_BUS-1:0] i_sda_o,
  input  logic [NUM_BUS-1:0] i_sda_t,
  output logic [NUM_BUS-1:0] i_sda_i,
  output logic [NUM_BUS-1:0] o_scl_o,
  input  logic [NUM_BUS-1:0] o_scl_i,
  output logic [NUM_BUS-1:0] o_scl_t,
  output logic [NUM_BUS-1:0] o_sda_o,
  input  logic [NUM_BUS-1:0] o_sda_i,
  output logic [NUM_BUS-1:0] o_sda_t,
  output logic [NUM_BUS-1:0] start_det,
  output logic [NUM_BUS-1:0] stop_det,
  output logic [NUM_BUS-1:0] bus_busy,
  output logic [NUM_BUS-1:0] stuck_low
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int SCW = (STUCK_CYCLES > 0) ? $clog2(STUCK_CYCLES + 1) : 1;
  localparam int NL  = 2 * NUM_BUS;

  logic [NL-1:0]      pin_raw;
  logic [NL-1:0]      line_f;
  logic [NUM_BUS-1:0] scl_f, sda_f;
  logic [NUM_BUS-1:0] scl_q_p2, sda_q_p2;
  logic [NUM_BUS-1:0] start_c, stop_c;

  // A driven 1 is turned into a release so the shim can only ever pull low.
  assign o_scl_o = '0;
  assign o_sda_o = '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_scl_t <= '1;
      o_sda_t <= '1;
    end else begin
      o_scl_t <= i_scl_t | i_scl_o;
      o_sda_t <= i_sda_t | i_sda_o;
    end
  end

  // Stage p0: synchroniser; stage p1: glitch filter. Lines 0..NUM_BUS-1 are SCL, the rest SDA.
  assign pin_raw = {o_sda_i, o_scl_i};

  for (genvar l = 0; l < NL; l++) begin : g_line
    logic [SYNC_STAGES-1:0] sync_p0;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sync_p0 <= '1;
      else         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin_raw[l]};
    end

    if (FILTER_LEN == 0) begin : g_bypass
      // Bypass takes the last synchroniser flop itself, keeping latency at SYNC_STAGES.
      assign line_f[l] = sync_p0[SYNC_STAGES-1];
    end else begin : g_filt
      logic           f_p1;
      logic [FCW-1:0] cnt_p1;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          f_p1   <= 1'b1;
          cnt_p1 <= '0;
        end else if (sync_p0[SYNC_STAGES-1] == f_p1) begin
          cnt_p1 <= '0;
        end else if (cnt_p1 == FCW'(FILTER_LEN - 1)) begin
          f_p1   <= sync_p0[SYNC_STAGES-1];
          cnt_p1 <= '0;
        end else begin
          cnt_p1 <= cnt_p1 + FCW'(1);
        end
      end

      assign line_f[l] = f_p1;
    end
  end

  assign scl_f   = line_f[NUM_BUS-1:0];
  assign sda_f   = line_f[NL-1:NUM_BUS];
  assign i_scl_i = scl_f;
  assign i_sda_i = sda_f;

  // Stage p2: delayed filtered copies and registered bus-condition status.
  assign start_c =  sda_q_p2 & ~sda_f & scl_q_p2 & scl_f;
  assign stop_c  = ~sda_q_p2 &  sda_f & scl_q_p2 & scl_f;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_q_p2  <= '1;
      sda_q_p2  <= '1;
      start_det <= '0;
      stop_det  <= '0;
      bus_busy  <= '0;
    end else begin
      scl_q_p2  <= scl_f;
      sda_q_p2  <= sda_f;
      start_det <= start_c;
      stop_det  <= stop_c;
      bus_busy  <= start_c | (bus_busy & ~stop_c);
    end
  end

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_stuck
    if (STUCK_CYCLES == 0) begin : g_off
      assign stuck_low[b] = 1'b0;
    end else begin : g_on
      logic [SCW-1:0] low_cnt;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                            low_cnt <= '0;
        else if (scl_f[b])                      low_cnt <= '0;
        else if (low_cnt != SCW'(STUCK_CYCLES)) low_cnt <= low_cnt + SCW'(1);
      end

      assign stuck_low[b] = (low_cnt == SCW'(STUCK_CYCLES));
    end
  end

endmodule

// File: tb/tb_i2c_shim_filt.sv
// Bench for i2c_shim_filt: directed scenarios with literal expectations plus
// randomized pin/controller activity checked every cycle against a behavioural model.
module tb_i2c_shim_filt;

  localparam int NB = 3;
  localparam int SY = 2;
  localparam int FL = 4;
  localparam int SC = 20;

  logic          clk;
  logic          resetn;
  logic [NB-1:0] scl_o, scl_t, sda_o, sda_t;
  logic [NB-1:0] pin_scl, pin_sda;
  logic [NB-1:0] i_scl_i, i_sda_i, o_scl_o, o_scl_t, o_sda_o, o_sda_t;
  logic [NB-1:0] start_det, stop_det, bus_busy, stuck_low;

  logic d2_scl_i, d2_sda_i, d2_scl_oo, d2_scl_ot, d2_sda_oo, d2_sda_ot;
  logic d2_start, d2_stop, d2_busy, d2_stuck;

  int ncmp = 0;
  int nerr = 0;
  bit cmp_en = 0;

  i2c_shim_filt #(.NUM_BUS(NB), .SYNC_STAGES(SY), .FILTER_LEN(FL), .STUCK_CYCLES(SC)) dut (
    .clk(clk), .resetn(resetn),
    .i_scl_o(scl_o), .i_scl_t(scl_t), .i_scl_i(i_scl_i),
    .i_sda_o(sda_o), .i_sda_t(sda_t), .i_sda_i(i_sda_i),
    .o_scl_o(o_scl_o), .o_scl_i(pin_scl), .o_scl_t(o_scl_t),
    .o_sda_o(o_sda_o), .o_sda_i(pin_sda), .o_sda_t(o_sda_t),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy), .stuck_low(stuck_low)
  );

  i2c_shim_filt #(.NUM_BUS(1), .SYNC_STAGES(SY), .FILTER_LEN(0), .STUCK_CYCLES(0)) dut2 (
    .clk(clk), .resetn(resetn),
    .i_scl_o(scl_o[0]), .i_scl_t(scl_t[0]), .i_scl_i(d2_scl_i),
    .i_sda_o(sda_o[0]), .i_sda_t(sda_t[0]), .i_sda_i(d2_sda_i),
    .o_scl_o(d2_scl_oo), .o_scl_i(pin_scl[0]), .o_scl_t(d2_scl_ot),
    .o_sda_o(d2_sda_oo), .o_sda_i(pin_sda[0]), .o_sda_t(d2_sda_ot),
    .start_det(d2_start), .stop_det(d2_stop), .bus_busy(d2_busy), .stuck_low(d2_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: pin sample history, a window of synchronised samples, and
  // the filtered value flips once the whole window disagrees with it.
  bit ph   [NB][2][8];
  bit win  [NB][2][FL];
  bit mf   [NB][2];
  bit mq   [NB][2];
  bit mst  [NB];
  bit msp  [NB];
  bit mbusy[NB];
  int scnt [NB];
  bit mot  [NB][2];

  always @(posedge clk or negedge resetn) begin
    bit st, sp, allc, pin;
    if (!resetn) begin
      for (int b = 0; b < NB; b++) begin
        for (int l = 0; l < 2; l++) begin
          for (int k = 0; k < 8; k++) ph[b][l][k] = 1'b1;
          for (int k = 0; k < FL; k++) win[b][l][k] = 1'b1;
          mf[b][l] = 1'b1; mq[b][l] = 1'b1; mot[b][l] = 1'b1;
        end
        mst[b] = 0; msp[b] = 0; mbusy[b] = 0; scnt[b] = 0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        st =  mq[b][1] & ~mf[b][1] & mq[b][0] & mf[b][0];
        sp = ~mq[b][1] &  mf[b][1] & mq[b][0] & mf[b][0];
        mst[b] = st;
        msp[b] = sp;
        if (st) mbusy[b] = 1'b1;
        else if (sp) mbusy[b] = 1'b0;
        if (mf[b][0]) scnt[b] = 0;
        else if (scnt[b] < SC) scnt[b] = scnt[b] + 1;
        for (int l = 0; l < 2; l++) begin
          pin = (l == 0) ? pin_scl[b] : pin_sda[b];
          for (int k = 7; k > 0; k--) ph[b][l][k] = ph[b][l][k-1];
          ph[b][l][0] = pin;
          for (int k = FL - 1; k > 0; k--) win[b][l][k] = win[b][l][k-1];
          win[b][l][0] = ph[b][l][SY];
          allc = 1'b1;
          for (int k = 0; k < FL; k++) if (win[b][l][k] == mf[b][l]) allc = 1'b0;
          mq[b][l] = mf[b][l];
          if (allc) mf[b][l] = ~mf[b][l];
        end
        mot[b][0] = scl_t[b] | scl_o[b];
        mot[b][1] = sda_t[b] | sda_o[b];
      end
    end
  end

  logic [NB-1:0] e_scl_i, e_sda_i, e_scl_t, e_sda_t, e_st, e_sp, e_busy, e_stuck;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int b = 0; b < NB; b++) begin
        e_scl_i[b] = mf[b][0];  e_sda_i[b] = mf[b][1];
        e_scl_t[b] = mot[b][0]; e_sda_t[b] = mot[b][1];
        e_st[b] = mst[b]; e_sp[b] = msp[b]; e_busy[b] = mbusy[b];
        e_stuck[b] = (scnt[b] == SC);
      end
      chk("m_scl_i",   32'(i_scl_i),   32'(e_scl_i));
      chk("m_sda_i",   32'(i_sda_i),   32'(e_sda_i));
      chk("m_scl_t",   32'(o_scl_t),   32'(e_scl_t));
      chk("m_sda_t",   32'(o_sda_t),   32'(e_sda_t));
      chk("m_outval",  32'({o_scl_o, o_sda_o}), 32'(0));
      chk("m_start",   32'(start_det), 32'(e_st));
      chk("m_stop",    32'(stop_det),  32'(e_sp));
      chk("m_busy",    32'(bus_busy),  32'(e_busy));
      chk("m_stuck",   32'(stuck_low), 32'(e_stuck));
    end
  end

  logic [1:0] od_pat [4];
  logic       od_exp [4];

  initial begin
    resetn = 1'b0;
    scl_o = '1; scl_t = '1; sda_o = '1; sda_t = '1;
    pin_scl = '1; pin_sda = '1;
    tick(3);
    cmp_en = 1'b1;
    chk("rst_scl_t", 32'(o_scl_t), 32'h7);
    chk("rst_sda_t", 32'(o_sda_t), 32'h7);
    chk("rst_sda_i", 32'(i_sda_i), 32'h7);
    chk("rst_busy",  32'(bus_busy), 32'h0);
    resetn = 1'b1;
    tick(2);

    // Open-drain mapping on bus 0 SCL: (o,t) pairs.
    od_pat[0] = 2'b00; od_pat[1] = 2'b10; od_pat[2] = 2'b01; od_pat[3] = 2'b11;
    od_exp[0] = 1'b0;  od_exp[1] = 1'b1;  od_exp[2] = 1'b1;  od_exp[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      scl_o[0] = od_pat[i][1];
      scl_t[0] = od_pat[i][0];
      tick(1);
      chk("od_scl_t", 32'(o_scl_t[0]), 32'(od_exp[i]));
      chk("od_scl_o", 32'(o_scl_o[0]), 32'(0));
    end
    tick(4);

    // Three-clock glitch must be swallowed.
    pin_sda[0] = 1'b0;
    tick(3);
    pin_sda[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("glitch3_sda_i", 32'(i_sda_i[0]), 32'(1));
    end

    // Four-clock low: START then STOP on bus 0, with exact latencies.
    pin_sda[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 1) chk("bypass_before", 32'(d2_sda_i), 32'(1));
      if (k == 2) chk("bypass_fall",   32'(d2_sda_i), 32'(0));
      if (k == 5) chk("filt_before",   32'(i_sda_i[0]), 32'(1));
      if (k == 5) chk("bypass_low",    32'(d2_sda_i), 32'(0));
      if (k == 6) chk("filt_fall",     32'(i_sda_i[0]), 32'(0));
      if (k == 6) chk("bypass_rise",   32'(d2_sda_i), 32'(1));
      if (k == 6) chk("start_early",   32'(start_det), 32'(0));
      if (k == 7) chk("start_pulse",   32'(start_det), 32'h1);
      if (k == 7) chk("busy_set",      32'(bus_busy), 32'h1);
      if (k == 8) chk("start_once",    32'(start_det), 32'(0));
      if (k == 9) chk("filt_still_lo", 32'(i_sda_i[0]), 32'(0));
      if (k == 10) chk("filt_rise",    32'(i_sda_i[0]), 32'(1));
      if (k == 11) chk("stop_pulse",   32'(stop_det), 32'h1);
      if (k == 11) chk("busy_clr",     32'(bus_busy), 32'h0);
      if (k == 4) pin_sda[0] = 1'b1;
    end
    chk("bypass_stuck_off", 32'(d2_stuck), 32'(0));

    // SCL and SDA moving together produce no condition.
    pin_scl[0] = 1'b0; pin_sda[0] = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      chk("same_clk_nopulse", 32'({start_det, stop_det}), 32'(0));
    end
    pin_scl[0] = 1'b1; pin_sda[0] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick(1);
      chk("same_clk_nopulse", 32'({start_det, stop_det}), 32'(0));
    end

    // START on bus 1 only; sub-filter glitches on bus 2.
    pin_sda[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 7) chk("mb_start", 32'(start_det), 32'h2);
      if (k == 7) chk("mb_busy",  32'(bus_busy), 32'h2);
    end
    for (int r = 0; r < 5; r++) begin
      pin_scl[2] = 1'b0; pin_sda[2] = 1'b0;
      tick(2);
      chk("mb_glitch_scl", 32'(i_scl_i), 32'h7);
      pin_sda[2] = 1'b1;
      tick(1);
      pin_scl[2] = 1'b1;
      tick(2);
      chk("mb_glitch_scl", 32'(i_scl_i), 32'h7);
      chk("mb_glitch_sda", 32'(i_sda_i), 32'h5);
      chk("mb_glitch_busy", 32'(bus_busy), 32'h2);
    end
    tick(6);

    // Stuck-low on bus 0 with threshold 20.
    pin_scl[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (k == 25) chk("stuck_before", 32'(stuck_low[0]), 32'(0));
      if (k == 26) chk("stuck_set",    32'(stuck_low[0]), 32'(1));
      if (k == 30) chk("stuck_hold",   32'(stuck_low[0]), 32'(1));
      if (k == 36) chk("stuck_hold2",  32'(stuck_low[0]), 32'(1));
      if (k == 37) chk("stuck_clr",    32'(stuck_low[0]), 32'(0));
      if (k == 30) pin_scl[0] = 1'b1;
    end
    pin_scl[0] = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      tick(1);
      if (k == 25) chk("stuck_restart", 32'(stuck_low[0]), 32'(0));
      if (k == 26) chk("stuck_reset2",  32'(stuck_low[0]), 32'(1));
    end
    pin_scl[0] = 1'b1;
    tick(10);

    // Reset in the middle of a busy transfer with SDA actively driven.
    sda_o[1] = 1'b0; sda_t[1] = 1'b0;
    tick(2);
    chk("pre_rst_sda_t", 32'(o_sda_t[1]), 32'(0));
    chk("pre_rst_busy",  32'(bus_busy[1]), 32'(1));
    #3 resetn = 1'b0;
    #1;
    chk("async_sda_t", 32'(o_sda_t), 32'h7);
    chk("async_scl_t", 32'(o_scl_t), 32'h7);
    chk("async_busy",  32'(bus_busy), 32'h0);
    sda_o[1] = 1'b1; sda_t[1] = 1'b1;
    pin_sda[1] = 1'b1;
    tick(2);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("post_rst_lines", 32'({i_scl_i, i_sda_i}), 32'h3f);
      chk("post_rst_pulse", 32'({start_det, stop_det, bus_busy}), 32'(0));
    end

    // Randomized activity on all buses, with one asynchronous reset midway.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(11) == 0) pin_scl[b] = ~pin_scl[b];
        if ($urandom_range(9) == 0)  pin_sda[b] = ~pin_sda[b];
      end
      scl_o = NB'($urandom); scl_t = NB'($urandom);
      sda_o = NB'($urandom); sda_t = NB'($urandom);
      if (c == 2000) begin
        #2 resetn = 1'b0;
        #1 chk("rand_async_t", 32'({o_scl_t, o_sda_t}), 32'h3f);
        tick(1);
        resetn = 1'b1;
      end
      tick(1);
    end
    pin_scl = '1; pin_sda = '1;
    tick(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
